// File: rtl/fetch_decode_unit_if.sv
// Instruction-memory read port between the fetch/decode front end and a synchronous ROM.
// The memory returns the addressed word one cycle after imem_en and holds it while imem_en is low.
interface fetch_decode_unit_if #(
    parameter int ADDR_W = 8
);
    logic              imem_en;
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       imem_rdata;

    modport master (output imem_en, output instr_addr, input imem_rdata);
    modport slave  (input imem_en, input instr_addr, output imem_rdata);
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode front end: PC, instruction register, decode, taken-branch redirect with
// wrong-path squash, stall freeze and a HALT/resume state machine.
module fetch_decode_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                zero_flag,
    input  logic                resume,
    fetch_decode_unit_if.master imem,
    output logic                dec_valid,
    output logic [ADDR_W-1:0]   d_pc,
    output logic [3:0]          opcode,
    output logic [2:0]          wreg_sig,
    output logic [2:0]          rreg_sig1,
    output logic [2:0]          rreg_sig2,
    output logic [5:0]          immediate,
    output logic                source2_select,
    output logic                alu_out_select,
    output logic                regwrite_flag,
    output logic                mem_write,
    output logic                pc_select,
    output logic [ADDR_W-1:0]   jump_addr,
    output logic                halted
);
    typedef enum logic [0:0] {ST_RUN, ST_HALT} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] pc_reg, f_pc_reg, d_pc_reg;
    logic              f_valid_reg, d_valid_reg;
    logic [15:0]       ir_reg;

    logic              is_r, is_i, is_ld, is_st, is_jmp, is_bz, is_halt;
    logic              running, advance, redirect, halt_take;
    logic [ADDR_W-1:0] bz_offset, bz_target, target, fetch_addr, pc_next;

    assign opcode    = ir_reg[15:12];
    assign wreg_sig  = ir_reg[11:9];
    assign rreg_sig1 = ir_reg[8:6];
    assign rreg_sig2 = ir_reg[5:3];
    assign immediate = ir_reg[5:0];

    assign is_r    = (opcode != 4'h0) && !opcode[3];
    assign is_i    = (opcode[3:2] == 2'b10);
    assign is_ld   = (opcode == 4'hC);
    assign is_st   = (opcode == 4'hD);
    assign is_jmp  = (opcode == 4'hE);
    assign is_bz   = (opcode == 4'hF) && !ir_reg[11];
    assign is_halt = (opcode == 4'hF) && ir_reg[11];

    // Sign-extend the 6-bit branch offset to the address width.
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_bz_sext
            if (gi < 6) begin : g_low
                assign bz_offset[gi] = ir_reg[gi];
            end else begin : g_high
                assign bz_offset[gi] = ir_reg[5];
            end
        end
    endgenerate

    assign bz_target = d_pc_reg + bz_offset;
    assign target    = is_jmp ? ir_reg[ADDR_W-1:0] : bz_target;

    assign running   = !rst && (state_reg == ST_RUN);
    assign dec_valid = running && d_valid_reg;
    assign advance   = running && !stall;
    assign redirect  = advance && d_valid_reg && (is_jmp || (is_bz && zero_flag));
    assign halt_take = advance && d_valid_reg && is_halt;

    // A taken redirect issues its target in the same cycle it is decoded.
    assign fetch_addr = redirect ? target : pc_reg;
    assign pc_next    = fetch_addr + 1'b1;

    assign imem.imem_en    = advance && !halt_take;
    assign imem.instr_addr = fetch_addr;

    assign d_pc           = d_pc_reg;
    assign jump_addr      = target;
    assign pc_select      = redirect;
    assign regwrite_flag  = dec_valid && (is_r || is_i || is_ld);
    assign source2_select = dec_valid && (is_i || is_ld || is_st);
    assign alu_out_select = dec_valid && is_ld;
    assign mem_write      = dec_valid && is_st;
    assign halted         = !rst && (state_reg == ST_HALT);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg      <= RESET_PC;
            f_valid_reg <= 1'b0;
            f_pc_reg    <= RESET_PC;
            ir_reg      <= 16'h0000;
            d_valid_reg <= 1'b0;
            d_pc_reg    <= RESET_PC;
            state_reg   <= ST_RUN;
        end else if (!stall) begin
            case (state_reg)
                ST_RUN: begin
                    if (halt_take) begin
                        // Younger fetches are dropped; resume restarts right after the HALT.
                        f_valid_reg <= 1'b0;
                        d_valid_reg <= 1'b0;
                        pc_reg      <= d_pc_reg + 1'b1;
                        state_reg   <= ST_HALT;
                    end else begin
                        pc_reg      <= pc_next;
                        f_valid_reg <= 1'b1;
                        f_pc_reg    <= fetch_addr;
                        ir_reg      <= imem.imem_rdata;
                        d_valid_reg <= f_valid_reg && !redirect;
                        d_pc_reg    <= f_pc_reg;
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_reg <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scoreboard bench: directed program images with a hand-written expected decode stream per
// instance; monitors pop and compare on every decoded instruction.
module tb_fetch_decode_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst6 = 1'b1;
    logic stall = 1'b0;
    logic zero_flag = 1'b0;
    logic resume = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] pc;
        logic [15:0] word;
        int          gap;
        logic [3:0]  flags;
        bit          ps;
        logic [11:0] ja;
    } exp_t;

    typedef struct {
        logic [11:0] pc;
        logic [12:0] hi;
        logic [5:0]  imm;
        logic [3:0]  flags;
        bit          ps;
        logic [11:0] ja;
    } obs_t;

    exp_t q8[$];
    exp_t q6[$];
    int   gap8 = 0;
    int   gap6 = 0;

    // ADDR_W=8 instance
    fetch_decode_unit_if #(.ADDR_W(8)) imem8 ();
    logic       dv8, src2_8, alu8, rw8, mw8, ps8, halted8;
    logic [7:0] d_pc8, ja8;
    logic [3:0] op8;
    logic [2:0] w8, ra8, rb8;
    logic [5:0] imm8;
    logic [15:0] rom8 [256];

    fetch_decode_unit #(.ADDR_W(8), .RESET_PC(8'h10)) dut8 (
        .clk(clk), .rst(rst), .stall(stall), .zero_flag(zero_flag), .resume(resume),
        .imem(imem8), .dec_valid(dv8), .d_pc(d_pc8), .opcode(op8), .wreg_sig(w8),
        .rreg_sig1(ra8), .rreg_sig2(rb8), .immediate(imm8), .source2_select(src2_8),
        .alu_out_select(alu8), .regwrite_flag(rw8), .mem_write(mw8), .pc_select(ps8),
        .jump_addr(ja8), .halted(halted8)
    );

    always @(posedge clk) if (imem8.imem_en) imem8.imem_rdata <= rom8[imem8.instr_addr];

    // ADDR_W=6 instance
    fetch_decode_unit_if #(.ADDR_W(6)) imem6 ();
    logic       dv6, src2_6, alu6, rw6, mw6, ps6, halted6;
    logic [5:0] d_pc6, ja6;
    logic [3:0] op6;
    logic [2:0] w6, ra6, rb6;
    logic [5:0] imm6;
    logic [15:0] rom6 [64];

    fetch_decode_unit #(.ADDR_W(6), .RESET_PC(6'h3C)) dut6 (
        .clk(clk), .rst(rst6), .stall(1'b0), .zero_flag(1'b0), .resume(1'b0),
        .imem(imem6), .dec_valid(dv6), .d_pc(d_pc6), .opcode(op6), .wreg_sig(w6),
        .rreg_sig1(ra6), .rreg_sig2(rb6), .immediate(imm6), .source2_select(src2_6),
        .alu_out_select(alu6), .regwrite_flag(rw6), .mem_write(mw6), .pc_select(ps6),
        .jump_addr(ja6), .halted(halted6)
    );

    always @(posedge clk) if (imem6.imem_en) imem6.imem_rdata <= rom6[imem6.instr_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input obs_t o, input int gap, input bit issue);
        chk({tag, "_pc"}, 32'(o.pc), 32'(e.pc));
        chk({tag, "_fields"}, 32'(o.hi), 32'(e.word[15:3]));
        chk({tag, "_imm"}, 32'(o.imm), 32'(e.word[5:0]));
        chk({tag, "_flags"}, 32'(o.flags), 32'(e.flags));
        chk({tag, "_pc_select"}, 32'(o.ps), issue ? 32'(e.ps) : 32'd0);
        if (issue) chk({tag, "_gap"}, 32'(gap), 32'(e.gap));
        if (issue && e.ps) chk({tag, "_jump_addr"}, 32'(o.ja), 32'(e.ja));
    endtask

    function automatic void exp8(logic [11:0] pc, logic [15:0] w, int gap, logic [3:0] fl, bit ps, logic [11:0] ja);
        exp_t e;
        e.pc = pc; e.word = w; e.gap = gap; e.flags = fl; e.ps = ps; e.ja = ja;
        q8.push_back(e);
    endfunction

    function automatic void exp6(logic [11:0] pc, logic [15:0] w, int gap, logic [3:0] fl, bit ps, logic [11:0] ja);
        exp_t e;
        e.pc = pc; e.word = w; e.gap = gap; e.flags = fl; e.ps = ps; e.ja = ja;
        q6.push_back(e);
    endfunction

    always @(negedge clk) begin
        obs_t o;
        o.pc = 12'(d_pc8); o.hi = {op8, w8, ra8, rb8}; o.imm = imm8;
        o.flags = {rw8, src2_8, alu8, mw8}; o.ps = ps8; o.ja = 12'(ja8);
        if (rst) begin
            gap8 = 0;
            chk("rst_imem_en8", 32'(imem8.imem_en), 32'd0);
            chk("rst_outputs8", 32'({dv8, halted8, rw8, src2_8, alu8, mw8, ps8}), 32'd0);
        end else if (dv8 && stall) begin
            if (q8.size() > 0) cmp_rec("stall8", q8[0], o, gap8, 1'b0);
            chk("stall_imem_en8", 32'(imem8.imem_en), 32'd0);
        end else if (dv8) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_dec8: d_pc %0h decoded, expected none", d_pc8);
            end else begin
                cmp_rec($sformatf("dec8@%0h", q8[0].pc), q8[0], o, gap8, 1'b1);
                void'(q8.pop_front());
            end
            gap8 = 0;
        end else begin
            gap8++;
            chk("idle_flags8", 32'({rw8, src2_8, alu8, mw8, ps8}), 32'd0);
        end
    end

    always @(negedge clk) begin
        obs_t o;
        o.pc = 12'(d_pc6); o.hi = {op6, w6, ra6, rb6}; o.imm = imm6;
        o.flags = {rw6, src2_6, alu6, mw6}; o.ps = ps6; o.ja = 12'(ja6);
        if (rst6) begin
            gap6 = 0;
            chk("rst_outputs6", 32'({imem6.imem_en, dv6, halted6, rw6, ps6}), 32'd0);
        end else if (dv6) begin
            if (q6.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_dec6: d_pc %0h decoded, expected none", d_pc6);
            end else begin
                cmp_rec($sformatf("dec6@%0h", q6[0].pc), q6[0], o, gap6, 1'b1);
                void'(q6.pop_front());
            end
            gap6 = 0;
        end else begin
            gap6++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) rom8[i] = 16'h0000;
        for (int i = 0; i < 64; i++) rom6[i] = 16'h0000;
        rom8[8'h10] = 16'h1248; rom8[8'h11] = 16'h2A51; rom8[8'h12] = 16'h3C9A;
        rom8[8'h13] = 16'h7FFF; rom8[8'h14] = 16'hE005; rom8[8'h15] = 16'h1111;
        rom8[8'h05] = 16'hE040; rom8[8'h06] = 16'h2222;
        rom8[8'h40] = 16'h8A01; rom8[8'h41] = 16'hE020; rom8[8'h42] = 16'h3333;
        rom8[8'h20] = 16'hF03C; rom8[8'h21] = 16'hD2C5; rom8[8'h22] = 16'hC283;
        rom8[8'h23] = 16'hE020; rom8[8'h24] = 16'h4444;
        rom8[8'h1C] = 16'h5555; rom8[8'h1D] = 16'hE002; rom8[8'h1E] = 16'h6666;
        rom8[8'h02] = 16'hF03C; rom8[8'h03] = 16'h1357;
        rom8[8'hFE] = 16'h9000; rom8[8'hFF] = 16'hB123;
        rom8[8'h00] = 16'hE030; rom8[8'h01] = 16'h1999;
        rom8[8'h30] = 16'hF800; rom8[8'h31] = 16'hA0C0; rom8[8'h32] = 16'h0000;
        rom8[8'h33] = 16'hF800; rom8[8'h34] = 16'h1111;

        rom6[6'h3C] = 16'h1001; rom6[6'h3D] = 16'h1002; rom6[6'h3E] = 16'h1003;
        rom6[6'h3F] = 16'h1004; rom6[6'h00] = 16'h1005; rom6[6'h01] = 16'hE0C5;
        rom6[6'h02] = 16'h2222; rom6[6'h05] = 16'h1006; rom6[6'h06] = 16'h1007;
        rom6[6'h07] = 16'hF800;

        // flags = {regwrite, src2, alu_out, mem_write}
        exp8(12'h010, 16'h1248, 2, 4'b1000, 0, 12'h000);
        exp8(12'h011, 16'h2A51, 0, 4'b1000, 0, 12'h000);
        exp8(12'h012, 16'h3C9A, 0, 4'b1000, 0, 12'h000);
        exp8(12'h013, 16'h7FFF, 0, 4'b1000, 0, 12'h000);
        exp8(12'h014, 16'hE005, 0, 4'b0000, 1, 12'h005);
        exp8(12'h005, 16'hE040, 1, 4'b0000, 1, 12'h040);
        exp8(12'h040, 16'h8A01, 1, 4'b1100, 0, 12'h000);
        exp8(12'h041, 16'hE020, 0, 4'b0000, 1, 12'h020);
        exp8(12'h020, 16'hF03C, 1, 4'b0000, 0, 12'h000);
        exp8(12'h021, 16'hD2C5, 0, 4'b0101, 0, 12'h000);
        exp8(12'h022, 16'hC283, 0, 4'b1110, 0, 12'h000);
        exp8(12'h023, 16'hE020, 0, 4'b0000, 1, 12'h020);
        exp8(12'h020, 16'hF03C, 1, 4'b0000, 1, 12'h01C);
        exp8(12'h01C, 16'h5555, 1, 4'b1000, 0, 12'h000);
        exp8(12'h01D, 16'hE002, 0, 4'b0000, 1, 12'h002);
        exp8(12'h002, 16'hF03C, 1, 4'b0000, 1, 12'h0FE);
        exp8(12'h0FE, 16'h9000, 1, 4'b1100, 0, 12'h000);
        exp8(12'h0FF, 16'hB123, 0, 4'b1100, 0, 12'h000);
        exp8(12'h000, 16'hE030, 0, 4'b0000, 1, 12'h030);
        exp8(12'h030, 16'hF800, 1, 4'b0000, 0, 12'h000);
        exp8(12'h031, 16'hA0C0, 5, 4'b1100, 0, 12'h000);
        exp8(12'h032, 16'h0000, 0, 4'b0000, 0, 12'h000);
        exp8(12'h033, 16'hF800, 0, 4'b0000, 0, 12'h000);
        exp8(12'h010, 16'h1248, 2, 4'b1000, 0, 12'h000);
        exp8(12'h011, 16'h2A51, 0, 4'b1000, 0, 12'h000);
        exp8(12'h012, 16'h3C9A, 0, 4'b1000, 0, 12'h000);

        exp6(12'h03C, 16'h1001, 2, 4'b1000, 0, 12'h000);
        exp6(12'h03D, 16'h1002, 0, 4'b1000, 0, 12'h000);
        exp6(12'h03E, 16'h1003, 0, 4'b1000, 0, 12'h000);
        exp6(12'h03F, 16'h1004, 0, 4'b1000, 0, 12'h000);
        exp6(12'h000, 16'h1005, 0, 4'b1000, 0, 12'h000);
        exp6(12'h001, 16'hE0C5, 0, 4'b0000, 1, 12'h005);
        exp6(12'h005, 16'h1006, 1, 4'b1000, 0, 12'h000);
        exp6(12'h006, 16'h1007, 0, 4'b1000, 0, 12'h000);
        exp6(12'h007, 16'hF800, 0, 4'b0000, 0, 12'h000);

        repeat (3) tick();
        rst = 1'b0;
        rst6 = 1'b0;
        #1;
        chk("first_fetch8", 32'({imem8.imem_en, imem8.instr_addr}), 32'({1'b1, 8'h10}));
        chk("first_fetch6", 32'({imem6.imem_en, imem6.instr_addr}), 32'({1'b1, 6'h3C}));

        // A resume pulse while running must not disturb the stream.
        repeat (3) tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;

        // Hold stall for three cycles over the LD.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = dv8 && (op8 == 4'hC);
        end
        chk("wait_ld", 32'(found), 32'd1);
        stall = 1'b1;
        zero_flag = 1'b1;
        repeat (3) tick();
        stall = 1'b0;

        // Stall over a valid JMP: no redirect until the stall drops.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = dv8 && (d_pc8 == 8'h23);
        end
        chk("wait_jmp23", 32'(found), 32'd1);
        stall = 1'b1;
        #1;
        chk("stall_jmp_pc_select", 32'(ps8), 32'd0);
        tick();
        chk("stall_jmp_pc_select", 32'(ps8), 32'd0);
        tick();
        stall = 1'b0;

        // First HALT: stay halted three cycles, then resume.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = halted8;
        end
        chk("wait_halt1", 32'(found), 32'd1);
        chk("halt_imem_en", 32'(imem8.imem_en), 32'd0);
        repeat (2) begin
            tick();
            chk("halt_hold", 32'({halted8, imem8.imem_en}), 32'({1'b1, 1'b0}));
        end
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_fetch", 32'({halted8, imem8.imem_en, imem8.instr_addr}), 32'({1'b0, 1'b1, 8'h31}));

        // Second HALT: reset while halted.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = halted8;
        end
        chk("wait_halt2", 32'(found), 32'd1);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_in_halt_fetch", 32'({halted8, imem8.imem_en, imem8.instr_addr}), 32'({1'b0, 1'b1, 8'h10}));

        for (int i = 0; i < 100 && (q8.size() != 0 || q6.size() != 0); i++) tick();
        chk("drain8", 32'(q8.size()), 32'd0);
        chk("drain6", 32'(q6.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
